vpifo_pop_scheduler: RTL

VPIFO_POP_SCHEDULER -- requirements
Module: vpifo_pop_scheduler

---
 rtl/vpifo_pop_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vpifo_pop_scheduler.sv
// Weighted round-robin pop scheduler for several logical PIFO trees sharing one datapath.
// Tracks per-tree occupancy, issues one pop at a time and waits (bounded) for its response.
module vpifo_pop_scheduler #(
  parameter int TREE_NUM  = 3,
  parameter int FIFO_SIZE = 2048,
  parameter int WEIGHT_W  = 4,
  parameter int TIMEOUT   = 64,
  localparam int CNT_W    = $clog2(FIFO_SIZE) + 1,
  localparam int TB       = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_push,
  input  logic [TB-1:0]         i_push_tree_id,
  input  logic                  i_task_fifo_full,
  output logic                  o_push_ready,
  input  logic                  i_cfg_we,
  input  logic [TB-1:0]         i_cfg_tree_id,
  input  logic [WEIGHT_W-1:0]   i_cfg_weight,
  output logic                  o_pop,
  output logic [TB-1:0]         o_pop_tree_id,
  input  logic                  i_pop_out,
  output logic                  o_busy,
  output logic                  o_timeout_err,
  output logic [CNT_W+TB-1:0]   o_occ_total
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(FIFO_SIZE);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      occ    [TREE_NUM];
  logic [WEIGHT_W-1:0]   weight [TREE_NUM];
  logic [TB-1:0]         ptr, ptr_nxt;
  logic [WEIGHT_W-1:0]   credit, credit_nxt;
  logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
  logic                  err, err_nxt;
  logic [TB-1:0]         pop_id, pop_id_nxt;
  logic [CNT_W+TB-1:0]   total;

  logic                  push_acc, issue, any_occ, keep, found;
  logic [CNT_W-1:0]      occ_push, occ_ptr;
  logic [TB-1:0]         hit;
  logic [WEIGHT_W-1:0]   hit_w;
  logic [TREE_NUM-1:0]   inc_v, dec_v;
  int unsigned           idx;

  always_comb begin
    occ_push = '0;
    occ_ptr  = '0;
    any_occ  = 1'b0;
    for (int unsigned i = 0; i < TREE_NUM; i++) begin
      if (i_push_tree_id == TB'(i)) occ_push = occ[i];
      if (ptr == TB'(i))            occ_ptr  = occ[i];
      if (occ[i] != '0)             any_occ  = 1'b1;
    end
  end

  assign o_push_ready = !i_rst && !i_task_fifo_full &&
                        ({1'b0, i_push_tree_id} < (TB+1)'(TREE_NUM)) &&
                        (occ_push < OCC_MAX);
  assign push_acc = i_push && o_push_ready;
  assign issue    = (state == ISSUE);

  always_comb begin
    for (int unsigned t = 0; t < TREE_NUM; t++) begin
      inc_v[t] = push_acc && (i_push_tree_id == TB'(t));
      dec_v[t] = issue && (ptr == TB'(t));
    end
  end

  // Search ptr+1 .. ptr+TREE_NUM, so the last step revisits ptr itself.
  always_comb begin
    keep  = (occ_ptr != '0) && (credit != '0);
    found = 1'b0;
    hit   = '0;
    hit_w = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= TREE_NUM; k++) begin
      idx = (32'(ptr) + k) % TREE_NUM;
      if (!found && occ[idx] != '0) begin
        found = 1'b1;
        hit   = TB'(idx);
        hit_w = weight[idx];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    to_cnt_nxt = to_cnt;
    err_nxt    = err;
    pop_id_nxt = pop_id;
    case (state)
      IDLE: if (i_en && any_occ) state_nxt = SELECT;
      SELECT: begin
        if (keep) begin
          pop_id_nxt = ptr;
          state_nxt  = ISSUE;
        end else if (found) begin
          ptr_nxt    = hit;
          credit_nxt = (hit_w == '0) ? WEIGHT_W'(1) : hit_w;
          pop_id_nxt = hit;
          state_nxt  = ISSUE;
        end else begin
          state_nxt  = IDLE;
        end
      end
      ISSUE: begin
        credit_nxt = credit - WEIGHT_W'(1);
        to_cnt_nxt = '0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (i_pop_out) begin
          state_nxt = IDLE;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ptr starts on the last tree so the first search after reset lands on tree 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      ptr    <= TB'(TREE_NUM - 1);
      credit <= '0;
      to_cnt <= '0;
      err    <= 1'b0;
      pop_id <= '0;
      total  <= '0;
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        occ[t]    <= '0;
        weight[t] <= WEIGHT_W'(1);
      end
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      to_cnt <= to_cnt_nxt;
      err    <= err_nxt;
      pop_id <= pop_id_nxt;
      if (push_acc && !issue)      total <= total + (CNT_W+TB)'(1);
      else if (issue && !push_acc) total <= total - (CNT_W+TB)'(1);
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        case ({inc_v[t], dec_v[t]})
          2'b10:   occ[t] <= occ[t] + CNT_W'(1);
          2'b01:   occ[t] <= occ[t] - CNT_W'(1);
          default: occ[t] <= occ[t];
        endcase
        if (i_cfg_we && i_cfg_tree_id == TB'(t)) weight[t] <= i_cfg_weight;
      end
    end
  end

  assign o_pop         = issue;
  assign o_pop_tree_id = pop_id;
  assign o_busy        = (state == ISSUE) || (state == WAIT);
  assign o_timeout_err = err;
  assign o_occ_total   = total;

endmodule
